// File: rtl/program_loader.sv
// program_loader: receives a framed byte stream, writes little-endian words into instruction memory,
// and holds the core in reset until the image checksum has been verified.
module program_loader #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              core_reset,
    output logic [31:0]       pc_start,
    output logic              done,
    output logic              error
);
    typedef enum logic [2:0] {IDLE, LEN, START, DATA, CHK, DONE, ERR} state_t;
    state_t state_q, state_d;
    logic [1:0]      byte_q;
    logic [ADDR_W:0] word_q, len_q;
    logic [31:0]     asm_q, tmo_q, val;
    logic [7:0]      chk_q;
    logic            accept, last, active, timed_out;
    assign accept    = rx_valid & rx_ready;
    assign val       = {rx_data, asm_q[31:8]};
    assign last      = accept && byte_q == 2'd3;
    assign active    = state_q inside {LEN, START, DATA, CHK};
    // An accepted byte always wins over an expiring idle count.
    assign timed_out = TIMEOUT != 0 && active && !accept && tmo_q == 32'(TIMEOUT - 1);
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept && rx_data == 8'hA5) state_d = LEN;
            LEN:   if (last) state_d = val > (32'd1 << ADDR_W) ? ERR : START;
            START: if (last) state_d = val[1:0] != 2'b00 ? ERR : (len_q == '0 ? CHK : DATA);
            DATA:  if (last && word_q + 1'b1 == len_q) state_d = CHK;
            CHK:   if (accept) state_d = rx_data == chk_q ? DONE : ERR;
            default: ;
        endcase
        if (timed_out) state_d = ERR;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            byte_q     <= '0;
            word_q     <= '0;
            len_q      <= '0;
            asm_q      <= '0;
            tmo_q      <= '0;
            chk_q      <= '0;
            rx_ready   <= 1'b0;
            im_we      <= 1'b0;
            im_addr    <= '0;
            im_wdata   <= '0;
            core_reset <= 1'b1;
            pc_start   <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_ready   <= !(state_d inside {DONE, ERR});
            core_reset <= state_d != DONE;
            done       <= state_d == DONE;
            error      <= state_d == ERR;
            im_we      <= 1'b0;
            tmo_q      <= (accept || !active) ? '0 : tmo_q + 1'b1;
            if (accept && state_q inside {LEN, START, DATA}) begin
                byte_q <= byte_q + 1'b1;
                asm_q  <= val;
                chk_q  <= chk_q ^ rx_data;
            end
            if (last && state_q == LEN) len_q <= val[ADDR_W:0];
            if (last && state_q == START && val[1:0] == 2'b00) pc_start <= val;
            if (last && state_q == DATA) begin
                im_we    <= 1'b1;
                im_addr  <= word_q[ADDR_W-1:0];
                im_wdata <= val;
                word_q   <= word_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed frames; expected memory writes go to a scoreboard queue checked by a monitor.
module tb_program_loader;
    logic        clk = 1'b0, reset = 1'b1, rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready, im_we, core_reset, done, error;
    logic [7:0]  im_addr;
    logic [31:0] im_wdata, pc_start;
    int          n_cmp = 0, n_bad = 0;
    logic [39:0] exp_q[$];
    logic [39:0] e;

    always #5 clk = ~clk;

    program_loader #(.ADDR_W(8), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .core_reset(core_reset),
        .pc_start(pc_start), .done(done), .error(error)
    );

    always @(negedge clk) begin
        if (im_we) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got addr=%02h data=%08h, required no write", im_addr, im_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({im_addr, im_wdata} !== e) begin
                    n_bad++;
                    $display("FAIL write: got addr=%02h data=%08h, required addr=%02h data=%08h",
                             im_addr, im_wdata, e[39:32], e[31:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, required %08h", name, got, exp);
        end
    endtask

    task automatic status(input string tag, input logic rdy, input logic cr, input logic dn, input logic er);
        check({tag, ".rx_ready"}, 32'(rx_ready), 32'(rdy));
        check({tag, ".core_reset"}, 32'(core_reset), 32'(cr));
        check({tag, ".done"}, 32'(done), 32'(dn));
        check({tag, ".error"}, 32'(error), 32'(er));
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send32(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send(8'(w >> (8 * i)));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    initial begin
        repeat (2) @(negedge clk);
        status("reset", 1'b0, 1'b1, 1'b0, 1'b0);
        check("reset.im_we", 32'(im_we), 32'd0);
        check("reset.im_addr", 32'(im_addr), 32'd0);
        check("reset.im_wdata", im_wdata, 32'd0);
        check("reset.pc_start", pc_start, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        status("idle", 1'b1, 1'b1, 1'b0, 1'b0);

        send(8'hA5); send32(32'd2); send32(32'd0);
        push(8'd0, 32'h00500093); send32(32'h00500093);
        push(8'd1, 32'h00A00113); send32(32'h00A00113);
        status("t1.pre_chk", 1'b1, 1'b1, 1'b0, 1'b0);
        send(8'h73);
        status("t1.done", 1'b0, 1'b0, 1'b1, 1'b0);
        check("t1.pc_start", pc_start, 32'h0);

        do_reset();
        send(8'hA5); send32(32'd2); send32(32'd0);
        push(8'd0, 32'h00500093); send32(32'h00500093);
        push(8'd1, 32'h00A00113); send32(32'h00A00113);
        send(8'h72);
        status("t2.bad_chk", 1'b0, 1'b1, 1'b0, 1'b1);
        send(8'hA5); send32(32'd0);
        status("t2.sticky", 1'b0, 1'b1, 1'b0, 1'b1);

        do_reset();
        send(8'hA5); send32(32'd257);
        status("t3.oversize", 1'b0, 1'b1, 1'b0, 1'b1);
        send32(32'd0);

        do_reset();
        send(8'hA5); send32(32'd0); send32(32'h2);
        status("t4.unaligned", 1'b0, 1'b1, 1'b0, 1'b1);
        do_reset();
        send(8'hA5); send32(32'd0); send32(32'd0);
        status("t4.empty_pre", 1'b1, 1'b1, 1'b0, 1'b0);
        send(8'h00);
        status("t4.empty", 1'b0, 1'b0, 1'b1, 1'b0);

        do_reset();
        send(8'hA5); send32(32'd2); send32(32'd0);
        push(8'd0, 32'h00500093); send32(32'h00500093);
        do_reset();
        send(8'h13); send(8'h00);
        repeat (20) @(negedge clk);
        status("t5.idle", 1'b1, 1'b1, 1'b0, 1'b0);
        send(8'hA5); send32(32'd2); send32(32'h00000100);
        push(8'd0, 32'h00500093); send32(32'h00500093);
        push(8'd1, 32'h00A00113); send32(32'h00A00113);
        send(8'h72);
        status("t5.done", 1'b0, 1'b0, 1'b1, 1'b0);
        check("t5.pc_start", pc_start, 32'h00000100);

        do_reset();
        send(8'hA5); send32(32'd1); send(8'h00); send(8'h00);
        repeat (15) @(negedge clk);
        status("t6.gap15", 1'b1, 1'b1, 1'b0, 1'b0);
        send(8'h00); send(8'h00);
        push(8'd0, 32'h44332211); send32(32'h44332211);
        send(8'h45);
        status("t6.done", 1'b0, 1'b0, 1'b1, 1'b0);
        do_reset();
        send(8'hA5); send32(32'd1); send(8'h00);
        repeat (15) @(negedge clk);
        check("t6.gap15b.error", 32'(error), 32'd0);
        @(negedge clk);
        status("t6.gap16", 1'b0, 1'b1, 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end
endmodule
